// File: rtl/cson_fetch_pkg.sv
// Shared fetch-stage types and constants: fetch state encoding, PC source selects, PC step.
package cson_fetch_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'b00,
        F_REQ  = 2'b01,
        F_WAIT = 2'b10,
        F_DONE = 2'b11
    } fetch_state_e;

    localparam logic [1:0]  PC_SEL_SEQ = 2'b00;
    localparam logic [1:0]  PC_SEL_B   = 2'b01;
    localparam logic [1:0]  PC_SEL_F   = 2'b10;
    localparam logic [31:0] PC_STEP    = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_mux.sv
// Combinational next-PC select: redirect target (word aligned) beats the +4 step at capture.
// No state, zero latency; pc_s=00 and pc_s=11 never move the PC on their own.
module fetch_pc_mux
    import cson_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pc_s_i,
    input  logic        load_i,
    input  logic        inc_i,
    input  logic [31:0] b_i,
    input  logic [31:0] f_i,
    output logic [31:0] pc_d_o,
    output logic        redirect_o
);

    always_comb begin
        redirect_o = load_i && ((pc_s_i == PC_SEL_B) || (pc_s_i == PC_SEL_F));
        pc_d_o     = pc_i;
        if (redirect_o) begin
            pc_d_o = (pc_s_i == PC_SEL_B) ? word_align(b_i) : word_align(f_i);
        end else if (inc_i) begin
            pc_d_o = pc_i + PC_STEP;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns PC/IR, runs the imem request/response handshake with timeout retry.
// W_IR_valid two cycles after write_ir at best; imem_req held until imem_gnt, redirects drop in-flight data.
module instr_fetch_unit
    import cson_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_ir,
    input  logic        write_pc,
    input  logic [1:0]  pc_s,
    input  logic [31:0] B,
    input  logic [31:0] F,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] IR,
    output logic        W_IR_valid,
    output logic        fetch_err
);

    localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d, ir_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             discard_q, discard_d;
    logic             req_q, irv_q, err_q;
    logic             redirect, redir_busy, rv_live, capture, timeout;

    fetch_pc_mux u_pc_mux (
        .pc_i       (pc_q),
        .pc_s_i     (pc_s),
        .load_i     (write_pc),
        .inc_i      (capture),
        .b_i        (B),
        .f_i        (F),
        .pc_d_o     (pc_d),
        .redirect_o (redirect)
    );

    always_comb begin
        redir_busy = redirect && ((state_q == F_REQ) || (state_q == F_WAIT));
        // A response arriving while discard is set belongs to an abandoned fetch.
        rv_live    = imem_rvalid && !discard_q;
        capture    = !redir_busy && rv_live &&
                     (((state_q == F_REQ) && imem_gnt) || (state_q == F_WAIT));
        timeout    = !redir_busy && !rv_live && (state_q == F_WAIT) && (cnt_q == CNT_LAST);

        state_d    = state_q;
        cnt_d      = cnt_q;
        discard_d  = discard_q && !imem_rvalid;

        case (state_q)
            F_IDLE: if (write_ir) state_d = F_REQ;
            F_REQ: begin
                if (imem_gnt) begin
                    state_d = capture ? F_DONE : F_WAIT;
                    cnt_d   = '0;
                end
            end
            F_WAIT: begin
                if (capture) begin
                    state_d = F_DONE;
                end else if (timeout) begin
                    state_d = F_REQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            F_DONE:  state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase

        if (redir_busy) begin
            state_d = F_REQ;
            cnt_d   = '0;
            // Only arm discard if a response is still owed to us after this cycle.
            if (((state_q == F_WAIT) || imem_gnt) && !rv_live) discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= F_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            irv_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            req_q     <= (state_d == F_REQ);
            irv_q     <= (state_d == F_DONE);
            err_q     <= timeout;
            if (capture) ir_q <= imem_rdata;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign PC         = pc_q;
    assign IR         = ir_q;
    assign W_IR_valid = irv_q;
    assign fetch_err  = err_q;

endmodule
